// File: rtl/registro_serie_paralelo.sv
// Serial-to-parallel receiver: assembles WIDTH-bit frames (LSB first) and holds
// the finished word behind a data_ready/ack handshake, with timeout and overrun flags.
//
// Handshake: data_ready marks an un-acknowledged word in data_out; a word is
// consumed on the rising clk edge where ack=1 and data_ready=1. A completion on
// that same edge reloads data_out and keeps data_ready high (no overrun).
module registro_serie_paralelo #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [WIDTH-1:0] assembled;
  logic [WIDTH-1:0] data_out_n;
  logic             data_ready_n;
  logic             timeout_n;
  logic             overrun_n;
  logic             last_bit;

  // Current shift register with the incoming bit dropped into its slot.
  always_comb begin
    assembled = shift_reg;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_cnt == CNT_W'(i)) assembled[i] = serial_in;
    end
  end

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    shift_n      = shift_reg;
    data_out_n   = data_out;
    data_ready_n = data_ready & ~ack;
    timeout_n    = 1'b0;
    overrun_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n   = S_RECV;
          bit_cnt_n = '0;
          gap_cnt_n = '0;
          shift_n   = '0;
        end
      end
      S_RECV: begin
        if (start) begin
          // Restart wins over a coincident bit, which is dropped.
          bit_cnt_n = '0;
          gap_cnt_n = '0;
          shift_n   = '0;
        end else if (bit_valid) begin
          shift_n   = assembled;
          gap_cnt_n = '0;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (last_bit) begin
            state_n      = S_IDLE;
            data_out_n   = assembled;
            data_ready_n = 1'b1;
            overrun_n    = data_ready & ~ack;
          end
        end else if (gap_cnt >= GAP_W'(TIMEOUT - 1)) begin
          state_n   = S_IDLE;
          gap_cnt_n = GAP_W'(TIMEOUT);
          timeout_n = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      data_ready  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      gap_cnt     <= gap_cnt_n;
      shift_reg   <= shift_n;
      data_out    <= data_out_n;
      data_ready  <= data_ready_n;
      timeout_err <= timeout_n;
      overrun     <= overrun_n;
    end
  end

  assign busy = (state == S_RECV);

endmodule
